// File: rtl/hps_pixel_receiver_if.sv
// Host-side Avalon-MM slave bus plus the frame-buffer write port of the
// HPS pixel receiver, bundled so both ends can share one connection.
interface hps_pixel_receiver_if;
    logic [2:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic        fb_wr_req;
    logic [18:0] fb_wr_addr;
    logic [23:0] fb_wr_data;
    logic        fb_wr_ack;
    logic        frame_done;

    // Receiver view: serves the host, drives the frame buffer.
    modport slave (
        input  address, read, write, writedata, fb_wr_ack,
        output readdata, waitrequest, fb_wr_req, fb_wr_addr, fb_wr_data, frame_done
    );

    // Host / frame-buffer view.
    modport master (
        output address, read, write, writedata, fb_wr_ack,
        input  readdata, waitrequest, fb_wr_req, fb_wr_addr, fb_wr_data, frame_done
    );
endinterface

// File: rtl/hps_pixel_receiver.sv
// HPS pixel receiver: the host writes XY and then RGB per pixel. Each pixel is
// range-checked, turned into a linear frame-buffer address, queued, and drained
// to the frame buffer over a req/ack handshake. Progress is readable back.
module hps_pixel_receiver #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    hps_pixel_receiver_if.slave bus
);
    localparam int          PW    = $clog2(FIFO_DEPTH);
    localparam logic [19:0] TOTAL = 20'(IMG_W * IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t        state;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [19:0]   accepted;
    logic [19:0]   acked;
    logic          error;
    logic [9:0]    x_lat;
    logic [9:0]    y_lat;
    logic          frame_done;
    logic [42:0]   mem [FIFO_DEPTH];

    logic          fifo_full;
    logic          fifo_req;
    logic          busy;
    logic          in_bounds;
    logic          ctrl_wr;
    logic          start_cmd;
    logic          abort_cmd;
    logic          start_ok;
    logic          rgb_accept;
    logic          push;
    logic          pop;
    logic          err_set;
    logic [18:0]   lin_addr;
    logic [42:0]   head;
    logic [PW-1:0] rd_nxt;
    logic [31:0]   rdata;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_req   = (count != '0);
    assign busy       = (state == S_ACTIVE) || (state == S_DRAIN);
    assign in_bounds  = (32'(x_lat) < 32'(IMG_W)) && (32'(y_lat) < 32'(IMG_H));
    // Both coordinates are range-checked before use, so 19 bits never wrap.
    assign lin_addr   = 19'(y_lat) * 19'(IMG_W) + 19'(x_lat);

    assign ctrl_wr    = bus.write && (bus.address == 3'd0);
    assign abort_cmd  = ctrl_wr && bus.writedata[1];
    assign start_cmd  = ctrl_wr && bus.writedata[0] && !bus.writedata[1];
    assign start_ok   = start_cmd && ((state == S_IDLE) || (state == S_DONE));

    // Only a full queue during ACTIVE can stall the host; fullness is judged
    // before any pop in the same cycle.
    assign bus.waitrequest = bus.write && (bus.address == 3'd2) && fifo_full && (state == S_ACTIVE);

    assign rgb_accept = bus.write && (bus.address == 3'd2) && !bus.waitrequest;
    assign push       = rgb_accept && (state == S_ACTIVE) && in_bounds;
    assign pop        = fifo_req && bus.fb_wr_ack;
    assign err_set    = (rgb_accept && ((state != S_ACTIVE) || !in_bounds)) ||
                        (start_cmd && busy);
    assign rd_nxt     = pop ? rd_ptr + PW'(1) : rd_ptr;

    // Outputs read zero whenever no request is pending, so reset and idle look alike.
    assign head           = mem[rd_ptr];
    assign bus.fb_wr_req  = fifo_req;
    assign bus.fb_wr_addr = fifo_req ? head[42:24] : 19'd0;
    assign bus.fb_wr_data = fifo_req ? head[23:0]  : 24'd0;
    assign bus.frame_done = frame_done;

    // Combinational register read mux, zero when not reading.
    always_comb begin
        rdata = 32'd0;
        if (bus.read) begin
            case (bus.address)
                3'd0:    rdata = {accepted, 8'd0, error, fifo_full, (state == S_DONE), busy};
                3'd3:    rdata = {12'd0, acked};
                default: rdata = 32'd0;
            endcase
        end
    end
    assign bus.readdata = rdata;

    // Pixel queue storage; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {lin_addr, bus.writedata[23:0]};
        end
    end

    // Control FSM, queue pointers, counters and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            accepted   <= 20'd0;
            acked      <= 20'd0;
            error      <= 1'b0;
            x_lat      <= 10'd0;
            y_lat      <= 10'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_ptr     <= rd_nxt;

            if (abort_cmd) begin
                // Keep only an in-flight head that is not being acked now.
                if (fifo_req && !pop) begin
                    count  <= (PW+1)'(1);
                    wr_ptr <= rd_ptr + PW'(1);
                end else begin
                    count  <= '0;
                    wr_ptr <= rd_nxt;
                end
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (PW+1)'(1);
                    2'b01:   count <= count - (PW+1)'(1);
                    default: count <= count;
                endcase
            end

            if (bus.write && (bus.address == 3'd1)) begin
                x_lat <= bus.writedata[19:10];
                y_lat <= bus.writedata[9:0];
            end

            if (start_ok) begin
                accepted <= 20'd0;
                acked    <= pop ? 20'd1 : 20'd0;
                error    <= 1'b0;
            end else begin
                if (push) accepted <= accepted + 20'd1;
                if (pop)  acked    <= acked + 20'd1;
                if (err_set) error <= 1'b1;
            end

            if (abort_cmd) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start_cmd) state <= S_ACTIVE;
                    end
                    S_ACTIVE: begin
                        if (push && (accepted == TOTAL - 20'd1)) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (!fifo_req) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hps_pixel_receiver.sv
// Directed bench for hps_pixel_receiver: a full-size instance for register,
// queue, bounds and abort behaviour, and a 4x2 instance for frame completion.
module tb_hps_pixel_receiver;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    hps_pixel_receiver_if bus();
    hps_pixel_receiver_if sbus();

    hps_pixel_receiver #(.IMG_W(640), .IMG_H(480), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    hps_pixel_receiver #(.IMG_W(4), .IMG_H(2), .FIFO_DEPTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host write on the full-size instance, riding out any stall.
    task automatic bw(input logic [2:0] a, input logic [31:0] d);
        int guard;
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        #1;
        guard = 0;
        while (bus.waitrequest === 1'b1 && guard < 50) begin
            @(negedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL bw_stall_timeout: waitrequest=%b, want 0 within 50 cycles", bus.waitrequest);
        end
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic br(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1;
        #1;
        d = bus.readdata;
        bus.read = 1'b0;
    endtask

    task automatic sbw(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sbus.address = a; sbus.writedata = d; sbus.write = 1'b1;
        @(posedge clk); #1;
        sbus.write = 1'b0;
    endtask

    task automatic sbr(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        sbus.address = a; sbus.read = 1'b1;
        #1;
        d = sbus.readdata;
        sbus.read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        br(3'd0, d);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, 32'd0); end
        br(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_acked: got %h want %h", d, 32'd0); end
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.fb_wr_req); end
        n_cmp++; if (bus.fb_wr_addr !== 19'd0 || bus.fb_wr_data !== 24'd0) begin
            n_fail++; $display("FAIL reset_fb_bus: got %h/%h want 0/0", bus.fb_wr_addr, bus.fb_wr_data); end
        n_cmp++; if (bus.waitrequest !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_wait_done: got %b/%b want 0/0", bus.waitrequest, bus.frame_done); end
    endtask

    task automatic test_single_pixel();
        logic [31:0] d;
        bw(3'd0, 32'h1);
        bw(3'd1, (32'd5 << 10) | 32'd2);
        bw(3'd2, 32'h00FF8040);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.fb_wr_req !== 1'b1 || bus.fb_wr_addr !== 19'd1285 || bus.fb_wr_data !== 24'hFF8040) begin
                n_fail++; $display("FAIL single_held%0d: got %b/%0d/%h want 1/1285/ff8040",
                                   i, bus.fb_wr_req, bus.fb_wr_addr, bus.fb_wr_data); end
            @(posedge clk); #1;
        end
        @(negedge clk); bus.fb_wr_ack = 1'b1;
        @(posedge clk); #1; bus.fb_wr_ack = 1'b0;
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop: got %b want 0", bus.fb_wr_req); end
        br(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL single_acked: got %h want %h", d, 32'd1); end
        br(3'd0, d);
        n_cmp++; if (d !== 32'h1001) begin n_fail++; $display("FAIL single_status: got %h want %h", d, 32'h1001); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            bw(3'd1, (32'(i) << 10) | 32'd1);
            bw(3'd2, 32'h100000 + 32'(i));
        end
        br(3'd0, d);
        n_cmp++; if (d !== 32'h9005) begin n_fail++; $display("FAIL bp_status_full: got %h want %h", d, 32'h9005); end
        bw(3'd1, (32'd8 << 10) | 32'd1);
        @(negedge clk);
        bus.address = 3'd2; bus.writedata = 32'h100008; bus.write = 1'b1;
        #1;
        n_cmp++; if (bus.waitrequest !== 1'b1) begin n_fail++; $display("FAIL bp_wait_9th: got %b want 1", bus.waitrequest); end
        @(negedge clk); bus.fb_wr_ack = 1'b1;
        #1;
        n_cmp++; if (bus.waitrequest !== 1'b1) begin n_fail++; $display("FAIL bp_wait_with_ack: got %b want 1", bus.waitrequest); end
        n_cmp++; if (bus.fb_wr_addr !== 19'd640 || bus.fb_wr_data !== 24'h100000) begin
            n_fail++; $display("FAIL bp_head0: got %0d/%h want 640/100000", bus.fb_wr_addr, bus.fb_wr_data); end
        @(posedge clk); #1; bus.fb_wr_ack = 1'b0;
        n_cmp++; if (bus.waitrequest !== 1'b0) begin n_fail++; $display("FAIL bp_wait_release: got %b want 0", bus.waitrequest); end
        @(posedge clk); #1; bus.write = 1'b0;
        for (int i = 1; i < 9; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus.fb_wr_req !== 1'b1 || bus.fb_wr_addr !== 19'(640 + i) || bus.fb_wr_data !== 24'(32'h100000 + i)) begin
                n_fail++; $display("FAIL bp_order%0d: got %b/%0d/%h want 1/%0d/%h",
                                   i, bus.fb_wr_req, bus.fb_wr_addr, bus.fb_wr_data, 640 + i, 32'h100000 + i); end
            bus.fb_wr_ack = 1'b1;
            @(posedge clk); #1; bus.fb_wr_ack = 1'b0;
        end
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", bus.fb_wr_req); end
        br(3'd3, d);
        n_cmp++; if (d !== 32'd10) begin n_fail++; $display("FAIL bp_acked: got %h want %h", d, 32'd10); end
    endtask

    task automatic test_bounds();
        logic [31:0] d;
        bw(3'd1, 32'd640 << 10);
        bw(3'd2, 32'h00ABCDEF);
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL oob_x_req: got %b want 0", bus.fb_wr_req); end
        br(3'd0, d);
        n_cmp++; if (d !== 32'hA009) begin n_fail++; $display("FAIL oob_x_status: got %h want %h", d, 32'hA009); end
        bw(3'd0, 32'h2);
        br(3'd0, d);
        n_cmp++; if (d !== 32'hA008) begin n_fail++; $display("FAIL abort_sticky_err: got %h want %h", d, 32'hA008); end
        bw(3'd0, 32'h1);
        br(3'd0, d);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL start_clears: got %h want %h", d, 32'h1); end
        bw(3'd1, 32'd480);
        bw(3'd2, 32'h00111111);
        br(3'd0, d);
        n_cmp++; if (d !== 32'h9) begin n_fail++; $display("FAIL oob_y_status: got %h want %h", d, 32'h9); end
        bw(3'd0, 32'h3);
        bw(3'd0, 32'h1);
        bw(3'd0, 32'h2);
        bw(3'd1, 32'd0);
        bw(3'd2, 32'h00123456);
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL idle_rgb_req: got %b want 0", bus.fb_wr_req); end
        br(3'd0, d);
        n_cmp++; if (d !== 32'h8) begin n_fail++; $display("FAIL idle_rgb_err: got %h want %h", d, 32'h8); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        bw(3'd0, 32'h1);
        bw(3'd0, 32'h1);
        br(3'd0, d);
        n_cmp++; if (d !== 32'h9) begin n_fail++; $display("FAIL start_while_active: got %h want %h", d, 32'h9); end
        for (int k = 1; k <= 4; k++) begin
            bw(3'd1, 32'(k) << 10);
            bw(3'd2, 32'h0A0000 + 32'(k));
        end
        bw(3'd0, 32'h2);
        n_cmp++; if (bus.fb_wr_req !== 1'b1 || bus.fb_wr_addr !== 19'd1 || bus.fb_wr_data !== 24'h0A0001) begin
            n_fail++; $display("FAIL abort_inflight: got %b/%0d/%h want 1/1/0a0001",
                               bus.fb_wr_req, bus.fb_wr_addr, bus.fb_wr_data); end
        br(3'd0, d);
        n_cmp++; if (d !== 32'h4008) begin n_fail++; $display("FAIL abort_status: got %h want %h", d, 32'h4008); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.fb_wr_req !== 1'b1) begin n_fail++; $display("FAIL abort_req_held: got %b want 1", bus.fb_wr_req); end
        @(negedge clk); bus.fb_wr_ack = 1'b1;
        @(posedge clk); #1; bus.fb_wr_ack = 1'b0;
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL abort_req_drop: got %b want 0", bus.fb_wr_req); end
        @(posedge clk); #1;
        n_cmp++; if (bus.fb_wr_req !== 1'b0) begin n_fail++; $display("FAIL abort_flushed: got %b want 0", bus.fb_wr_req); end
        br(3'd3, d);
        n_cmp++; if (d !== 32'd1) begin n_fail++; $display("FAIL abort_acked: got %h want %h", d, 32'd1); end
    endtask

    task automatic test_frame_done();
        logic [31:0] d;
        sbw(3'd0, 32'h1);
        for (int i = 0; i < 8; i++) begin
            sbw(3'd1, (32'(i % 4) << 10) | 32'(i / 4));
            sbw(3'd2, 32'h200000 + 32'(i));
            n_cmp++; if (sbus.fb_wr_req !== 1'b1 || sbus.fb_wr_addr !== 19'(i) || sbus.fb_wr_data !== 24'(32'h200000 + i)) begin
                n_fail++; $display("FAIL frame_px%0d: got %b/%0d/%h want 1/%0d/%h",
                                   i, sbus.fb_wr_req, sbus.fb_wr_addr, sbus.fb_wr_data, i, 32'h200000 + i); end
            @(negedge clk); sbus.fb_wr_ack = 1'b1;
            @(posedge clk); #1; sbus.fb_wr_ack = 1'b0;
        end
        n_cmp++; if (sbus.frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_early: got %b want 0", sbus.frame_done); end
        sbr(3'd0, d);
        n_cmp++; if (d !== 32'h8001) begin n_fail++; $display("FAIL frame_drain_status: got %h want %h", d, 32'h8001); end
        @(posedge clk); #1;
        n_cmp++; if (sbus.frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b want 1", sbus.frame_done); end
        @(posedge clk); #1;
        n_cmp++; if (sbus.frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_width: got %b want 0", sbus.frame_done); end
        sbr(3'd0, d);
        n_cmp++; if (d !== 32'h8002) begin n_fail++; $display("FAIL frame_done_status: got %h want %h", d, 32'h8002); end
        sbr(3'd3, d);
        n_cmp++; if (d !== 32'd8) begin n_fail++; $display("FAIL frame_acked: got %h want %h", d, 32'd8); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bw(3'd0, 32'h1);
        bw(3'd1, (32'd3 << 10) | 32'd3);
        bw(3'd2, 32'h00C0FFEE);
        bw(3'd2, 32'h00BEEF00);
        n_cmp++; if (bus.fb_wr_req !== 1'b1 || bus.fb_wr_addr !== 19'd1923) begin
            n_fail++; $display("FAIL mid_pending: got %b/%0d want 1/1923", bus.fb_wr_req, bus.fb_wr_addr); end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.fb_wr_req !== 1'b0 || bus.fb_wr_addr !== 19'd0 || bus.fb_wr_data !== 24'd0 ||
                     bus.waitrequest !== 1'b0 || bus.frame_done !== 1'b0 || bus.readdata !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got req=%b addr=%0d data=%h wait=%b done=%b rd=%h want all 0",
                               bus.fb_wr_req, bus.fb_wr_addr, bus.fb_wr_data, bus.waitrequest, bus.frame_done, bus.readdata); end
        rst_n = 1'b1;
        br(3'd0, d);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL mid_reset_status: got %h want %h", d, 32'd0); end
        br(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL mid_reset_acked: got %h want %h", d, 32'd0); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.address = 3'd0;  bus.read = 1'b0;  bus.write = 1'b0;  bus.writedata = 32'd0;  bus.fb_wr_ack = 1'b0;
        sbus.address = 3'd0; sbus.read = 1'b0; sbus.write = 1'b0; sbus.writedata = 32'd0; sbus.fb_wr_ack = 1'b0;
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_bounds();
        test_abort();
        test_frame_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded 200000, want completion earlier");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hps_pixel_receiver.md
Name: hps_pixel_receiver

Overview:
- Avalon-MM slave that lets the HPS push a whiteboard image into the FPGA frame buffer one pixel at a time.
- Counterpart to the camera-to-HPS pixel transfer path, running in the opposite direction.
- CPU writes pixel coordinates, then RGB. Each pixel is bounds-checked, converted to a linear address, queued in a small FIFO and drained to the frame-buffer write port with a req/ack handshake.
- Status and progress are readable over the same slave.

Parameters:
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- FIFO_DEPTH, 8, pixel queue depth (power of two, >=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- address  in  3  slave word address.
- read  in  1  slave read strobe.
- readdata  out  32  slave read data.
- write  in  1  slave write strobe.
- writedata  in  32  slave write data.
- waitrequest  out  1  slave stall.
- fb_wr_req  out  1  frame-buffer write request.
- fb_wr_addr  out  19  linear pixel address, y*IMG_W+x.
- fb_wr_data  out  24  {R,G,B}.
- fb_wr_ack  in  1  frame buffer accepted the current request.
- frame_done  out  1  one-cycle pulse when the full frame has been written.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values: readdata=0, waitrequest=0, fb_wr_req=0, fb_wr_addr=0, fb_wr_data=0, frame_done=0. FIFO empty, counters 0, error=0, xy latch 0, state IDLE.
- Register map:
  - Address 0 write, CTRL: bit0=start, bit1=abort (abort wins if both set).
  - Address 0 read, STATUS: [0]=busy (ACTIVE or DRAIN), [1]=done, [2]=fifo_full, [3]=error (sticky), [31:12]=accepted pixel count.
  - Address 1 write, XY: x=writedata[19:10], y=writedata[9:0]. Latched only; no push.
  - Address 2 write, RGB: writedata[23:0] pushes {y*IMG_W+x, rgb} into the FIFO.
  - Address 3 read: 20-bit count of pixels acked by the frame buffer, zero-extended.
  - Other addresses: reads return 0, writes are ignored.
- readdata: combinational, valid in the same cycle as read. It is 0 when read=0.
- waitrequest: combinational. waitrequest = write && address==2 && fifo_full && state==ACTIVE. The host holds signals until waitrequest drops. No other access stalls.
- States:
  - IDLE: start -> ACTIVE, clears accepted/acked counts and done.
  - ACTIVE: each valid RGB write increments the accepted count. When the accepted count reaches IMG_W*IMG_H -> DRAIN.
  - DRAIN: FIFO empty and fb_wr_req=0 -> DONE, with frame_done=1 for exactly one cycle.
  - DONE: start -> ACTIVE, same clearing as IDLE.
  - Abort in any state -> IDLE. Queued entries are flushed, but an in-flight request (fb_wr_req=1) is held until its ack, then dropped.
- Bounds: RGB write with x>=IMG_W or y>=IMG_H is not pushed, is not counted, and sets error.
- Protocol errors (set error):
  - RGB write outside ACTIVE.
  - start while ACTIVE or DRAIN; the start is ignored.
  - error clears only on start from IDLE/DONE, or on reset.
- Address arithmetic: computed combinationally at push time in 19 bits. No wrap, because inputs are range-checked first.
- Drain handshake:
  - fb_wr_req is high whenever the FIFO is non-empty; fb_wr_addr/fb_wr_data show the FIFO head.
  - Request signals stay stable until fb_wr_ack. An ack in a cycle where req=1 pops the head.
  - The next entry is presented the following cycle, giving 1 pixel/cycle peak throughput.
  - fb_wr_ack while req=0 is ignored.
- Latency: an RGB write accepted at edge N gives fb_wr_req=1 after edge N (FIFO previously empty).
- Simultaneous push and pop: both occur and occupancy is unchanged. fifo_full is evaluated before the pop, so a full FIFO still stalls in that cycle.
- Reset mid-transfer: everything returns to reset values immediately, including dropping fb_wr_req.

Test Plan:
- Reset, then read addr0 -> 0. Read addr3 -> 0. fb_wr_req=0.
- start; XY x=5,y=2; RGB 0x00FF8040; ack after 3 cycles -> fb_wr_addr=1285, fb_wr_data=0xFF8040, held 3 cycles; addr3 reads 1.
- fb_wr_ack held low, 9 RGB writes (FIFO_DEPTH=8) -> 9th write sees waitrequest=1 and STATUS[2]=1. One ack releases it. All 9 pixels emerge in order.
- XY x=640,y=0 then RGB -> no fb_wr_req, STATUS[3]=1, count unchanged. An RGB write while IDLE also sets error.
- IMG_W=4, IMG_H=2: start, 8 pixels, ack each -> busy falls, done=1, frame_done pulses exactly 1 cycle after the last ack.
- Abort with 3 queued entries and req pending -> req held until ack, then 0. State IDLE. rst_n low mid-transfer -> all outputs 0 on the next edge.
